// File: rtl/mem_access_ctrl.sv
// Memory access stage between the CPU control unit and a synchronous single-port RAM.
// Runs one multi-cycle access per request edge, with configurable wait states and a stall output.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [31:0]           MAR_in,
    input  logic [DATA_WIDTH-1:0] MDR_in,
    output logic [DATA_WIDTH-1:0] Mdata_out,
    output logic                  Mem_busy,
    output logic                  Mem_done,
    output logic                  Addr_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    // state   | meaning
    // IDLE    | waiting for Read/Write; address and data latched on acceptance
    // ACCESS  | wait-state countdown; RAM strobe fires when the counter hits zero
    // CAPTURE | read data from the RAM is registered into Mdata_out
    // DONE    | one-cycle completion (and address-error) pulse
    // RELEASE | hold off until the request is dropped, so a held strobe runs once
    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE,
        RELEASE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       op_write;
    logic       op_err;
    logic       req;
    logic       addr_hi_err;

    assign req         = Read | Write;
    assign addr_hi_err = (MAR_in >> ADDR_WIDTH) != 32'd0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt  <= 4'd0;
            op_write  <= 1'b0;
            op_err    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            Mdata_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        ram_addr  <= MAR_in[ADDR_WIDTH-1:0];
                        ram_wdata <= MDR_in;
                        op_write  <= Write;
                        op_err    <= addr_hi_err;
                        wait_cnt  <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    // Out-of-range reads return zero rather than stale RAM output.
                    Mdata_out <= op_err ? '0 : ram_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        Mem_busy   = 1'b0;
        Mem_done   = 1'b0;
        Addr_err   = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state)
            IDLE: begin
                Mem_busy = req;
                if (req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                Mem_busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    ram_we     = op_write & ~op_err;
                    ram_re     = ~op_write & ~op_err;
                    state_next = op_write ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                Mem_busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Mem_busy   = 1'b1;
                Mem_done   = 1'b1;
                Addr_err   = op_err;
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side stage directly downstream of the CPU control unit.
- Takes the control unit's Read/Write strobes and the MAR/MDR contents, and runs a multi-cycle access on a synchronous single-port RAM with configurable wait states.
- Returns read data for the MDR and raises Mem_busy so the control unit holds its current state until the access completes.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width (512 words).
- DATA_WIDTH, 32, data word width.
- WAIT_STATES, 2, extra RAM cycles before the strobe (0..15).

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Read  in  1  read request from the control unit (level).
- Write  in  1  write request from the control unit (level).
- MAR_in  in  32  byte-free word address from the MAR.
- MDR_in  in  DATA_WIDTH  write data from the MDR.
- Mdata_out  out  DATA_WIDTH  registered read data, to the MDR mux.
- Mem_busy  out  1  stall to the control unit.
- Mem_done  out  1  one-cycle completion pulse.
- Addr_err  out  1  one-cycle pulse: MAR_in[31:ADDR_WIDTH] was nonzero.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re.

Behaviour:
- Clock/reset: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset values: state IDLE; Mdata_out, ram_addr, ram_wdata = 0; ram_we, ram_re, Mem_done, Addr_err = 0; wait counter = 0.
- States: IDLE, ACCESS, CAPTURE, DONE, RELEASE.
- req = Read | Write.
- Mem_busy is combinational: 1 when (IDLE && req) or state in {ACCESS, CAPTURE, DONE}; 0 in RELEASE.
- IDLE with req at edge:
  - latch ram_addr <= MAR_in[ADDR_WIDTH-1:0] and ram_wdata <= MDR_in;
  - latch op: Write has priority if Read and Write are both high;
  - latch err = |MAR_in[31:ADDR_WIDTH];
  - load counter = WAIT_STATES; go to ACCESS.
- ACCESS:
  - decrement counter each cycle;
  - in the cycle where counter==0, ram_we = write && !err and ram_re = read && !err, each high for exactly one cycle;
  - next state: CAPTURE for reads, DONE for writes.
- CAPTURE: Mdata_out <= ram_rdata (or 0 if err); go to DONE.
- DONE:
  - Mem_done = 1 and Addr_err = err for this one cycle;
  - Mdata_out holds its value until the next read completes;
  - go to RELEASE.
- RELEASE: stay while req is still high; go to IDLE when req = 0. This prevents a held strobe from starting a second access.
- Latency (request sampled at edge E0): ACCESS lasts WAIT_STATES+1 cycles.
  - Write: Mem_done in cycle WAIT_STATES+2 after E0.
  - Read: Mem_done in cycle WAIT_STATES+3 after E0.
- Address error: no RAM strobe; Mem_done is still issued; read data returns 0.
- Request dropped mid-access: the access completes anyway; RELEASE falls through immediately.
- Reset mid-access: abort at that edge; ram_we/ram_re low from that edge; no Mem_done.
- MAR_in and MDR_in changes after acceptance are ignored.

Test Plan:
- Write, WAIT_STATES=2: Write=1, MAR_in=0x0000_0055, MDR_in=0xDEAD_BEEF held -> ram_we exactly 1 cycle at addr 0x055, data 0xDEADBEEF; Mem_done 4 cycles after sample; Mem_busy=1 from the request cycle through DONE.
- Read-back: Read=1, MAR_in=0x55, RAM holds 0xDEADBEEF -> ram_re 1 cycle; Mdata_out=0xDEADBEEF when Mem_done pulses 5 cycles after sample; value held afterwards.
- Held strobe: keep Read=1 for 12 cycles -> exactly one ram_re pulse and one Mem_done; Mem_busy=0 in RELEASE; a new access starts only after Read drops and rises again.
- Conflict and range: Read=Write=1, MAR_in=0x40 -> write performed, no ram_re. MAR_in=0x0000_0200 with Read -> no strobe, Addr_err and Mem_done pulse together, Mdata_out=0.
- Reset mid-op: assert Reset in the 2nd ACCESS cycle of a write -> no ram_we, no Mem_done, all outputs 0 after the edge; a subsequent read works normally.
- WAIT_STATES=0: read -> ram_re in the first ACCESS cycle; Mem_done 3 cycles after sample.
